// File: rtl/shl_seq_pkg.sv
// -----------------------------------------------------------------------------
// shl_seq_pkg
// Shared definitions for the sequential left shifter (shl_seq) and its
// combinational step unit (shl_step).
//
// Contents:
//   state_t       FSM state encoding (IDLE, SHIFT)
//   DEFAULT_STEP  default number of bit positions moved per cycle
//   min_k()       helper returning the per-cycle step size for a given
//                 remaining shift count
//
// Optional feature macro seen by users of this package: SHL_SEQ_ROTATE_EN
// (rotate instead of logical shift). The package itself is identical in
// both builds.
// -----------------------------------------------------------------------------
package shl_seq_pkg;

  // Two-state controller: waiting for a request, or working through the
  // remaining shift count in STEP-sized chunks.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_STEP = 8;

  // Step size for the current cycle: the whole remainder when it fits in
  // one step, otherwise a full step. Widths are passed in so the helper
  // works for any DATAWIDTH the top is built with.
  function automatic int min_k(input int rem, input int step);
    return (rem < step) ? rem : step;
  endfunction

endpackage : shl_seq_pkg

// File: rtl/shl_step.sv
// -----------------------------------------------------------------------------
// shl_step
// Combinational single-step unit of the sequential shifter. Moves acc left
// by k bit positions in one pass.
//
// Build option:
//   SHL_SEQ_ROTATE_EN defined   : rotate left, bits leaving the MSB re-enter
//                                 at the LSB
//   SHL_SEQ_ROTATE_EN undefined : logical shift left, vacated bits are zero
//                                 (no rotate logic is built)
//
// Parameters:
//   DATAWIDTH  width of the operand
//   KW         width of the step amount (enough to hold DATAWIDTH itself)
//
// Ports:
//   acc  in   DATAWIDTH  value to be stepped
//   k    in   KW         bit positions to move this cycle (0..STEP)
//   res  out  DATAWIDTH  stepped value
// -----------------------------------------------------------------------------
module shl_step #(
  parameter int DATAWIDTH = 64,
  parameter int KW        = $clog2(DATAWIDTH) + 1
) (
  input  logic [DATAWIDTH-1:0] acc,
  input  logic [KW-1:0]        k,
  output logic [DATAWIDTH-1:0] res
);

`ifdef SHL_SEQ_ROTATE_EN

  localparam logic [KW-1:0] DW_K = KW'(DATAWIDTH);

  logic [KW-1:0] back;

  // The bits pushed out of the top come back from the bottom. For k=0 the
  // right shift is by the full width, which yields zero, so the result
  // collapses to acc unchanged as it should.
  always_comb begin
    back = DW_K - k;
    res  = (acc << k) | (acc >> back);
  end

`else

  always_comb begin
    res = acc << k;
  end

`endif

endmodule : shl_step

// File: rtl/shl_seq.sv
// -----------------------------------------------------------------------------
// shl_seq
// Multi-cycle left shifter. A request captured in IDLE is worked off at most
// STEP bit positions per clock; when the remaining count reaches zero the
// accumulator is copied to d and done pulses for one cycle.
//
// Build option (macro): SHL_SEQ_ROTATE_EN
//   defined   : effective amount is sh_amt mod DATAWIDTH, each step rotates
//   undefined : effective amount saturates at DATAWIDTH, so any shift of
//               DATAWIDTH or more produces zero
//
// Parameters:
//   DATAWIDTH  operand / result / shift-amount width (power of two, >= 8)
//   STEP       max bit positions per cycle (power of two, <= DATAWIDTH)
//
// Ports:
//   clk     in   1          rising-edge clock
//   rst     in   1          asynchronous active-high reset
//   start   in   1          request, only looked at while idle
//   a       in   DATAWIDTH  operand, captured when start is accepted
//   sh_amt  in   DATAWIDTH  unsigned shift amount, captured with a
//   busy    out  1          high while an operation is being worked off
//   done    out  1          one-cycle pulse, d holds a fresh result
//   d       out  DATAWIDTH  registered result, held until the next done
//
// Latency: ceil(amt_eff/STEP) + 1 cycles from the accepting edge to done.
// -----------------------------------------------------------------------------
module shl_seq
  import shl_seq_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int STEP      = DEFAULT_STEP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] sh_amt,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] d
);

  // Remaining-count width: must be able to hold DATAWIDTH itself, which is
  // the saturated amount in the logical-shift build.
  localparam int RW = $clog2(DATAWIDTH) + 1;

  localparam logic [RW-1:0] STEP_R = RW'(STEP);

  state_t                 state;
  state_t                 state_nxt;
  logic [DATAWIDTH-1:0]   acc;
  logic [DATAWIDTH-1:0]   acc_step;
  logic [RW-1:0]          rem;
  logic [RW-1:0]          amt_eff;
  logic [RW-1:0]          k;
  logic                   accept;
  logic                   finish;

`ifdef SHL_SEQ_ROTATE_EN

  // Rotating by a multiple of the width is a no-op, so only the low
  // log2(DATAWIDTH) bits of the amount matter.
  always_comb begin
    amt_eff = {1'b0, sh_amt[RW-2:0]};
  end

`else

  localparam logic [DATAWIDTH-1:0] DW_FULL = DATAWIDTH'(DATAWIDTH);
  localparam logic [RW-1:0]        DW_R    = RW'(DATAWIDTH);

  // Anything at or beyond the width shifts every bit out, so clamp it to
  // exactly the width; that keeps rem narrow and still yields zero.
  always_comb begin
    if (sh_amt >= DW_FULL) begin
      amt_eff = DW_R;
    end else begin
      amt_eff = sh_amt[RW-1:0];
    end
  end

`endif

  // Step size for this cycle: the whole remainder if it fits, else STEP.
  always_comb begin
    if (rem < STEP_R) begin
      k = rem;
    end else begin
      k = STEP_R;
    end
  end

  shl_step #(
    .DATAWIDTH (DATAWIDTH),
    .KW        (RW)
  ) u_step (
    .acc (acc),
    .k   (k),
    .res (acc_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and control decode. start is only honoured from IDLE, which
  // is what makes requests during an operation disappear without queuing.
  // The cycle done is high is already an IDLE cycle, so a start there is
  // taken immediately for back-to-back operation.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    finish    = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (rem == '0) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Datapath registers. acc/rem load on acceptance and then advance one
  // step per cycle until rem runs out; d only changes on completion, so it
  // keeps the last result through the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      rem  <= '0;
      d    <= '0;
      done <= 1'b0;
    end else begin
      done <= finish;
      if (accept) begin
        acc <= a;
        rem <= amt_eff;
      end else if ((state == SHIFT) && (rem != '0)) begin
        acc <= acc_step;
        rem <= rem - k;
      end
      if (finish) begin
        d <= acc;
      end
    end
  end

endmodule : shl_seq

// File: tb/tb_shl_seq.sv
// -----------------------------------------------------------------------------
// tb_shl_seq
// Self-checking bench for shl_seq (DATAWIDTH=64, STEP=8). Expected results
// come from a plain arithmetic model of the shifter; the model follows the
// SHL_SEQ_ROTATE_EN macro the same way the design does.
// -----------------------------------------------------------------------------
module tb_shl_seq;

  localparam int DW   = 64;
  localparam int STP  = 8;
  localparam int TOUT = 100;

  logic          clk;
  logic          rst;
  logic          start;
  logic [DW-1:0] a;
  logic [DW-1:0] sh_amt;
  logic          busy;
  logic          done;
  logic [DW-1:0] d;

  int n_cmp;
  int n_err;

  shl_seq #(
    .DATAWIDTH (DW),
    .STEP      (STP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .sh_amt (sh_amt),
    .busy   (busy),
    .done   (done),
    .d      (d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: what the shifter should return for a given request.
  function automatic logic [DW-1:0] model_d(input logic [DW-1:0] av, input logic [DW-1:0] sv);
    int amt;
`ifdef SHL_SEQ_ROTATE_EN
    amt = int'(sv % DW);
    if (amt == 0) return av;
    return (av << amt) | (av >> (DW - amt));
`else
    if (sv >= DW) return '0;
    amt = int'(sv);
    return av << amt;
`endif
  endfunction

  // Reference: cycles from the accepting edge until done is seen high.
  function automatic int model_lat(input logic [DW-1:0] sv);
    int amt;
`ifdef SHL_SEQ_ROTATE_EN
    amt = int'(sv % DW);
`else
    amt = (sv >= DW) ? DW : int'(sv);
`endif
    return (amt + STP - 1) / STP + 1;
  endfunction

  function automatic logic [DW-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Drives one request (called just after a rising edge), scrambles the
  // operands after acceptance, then waits (bounded) for done.
  task automatic do_op(input logic [DW-1:0] av, input logic [DW-1:0] sv,
                       output logic [DW-1:0] got, output int lat,
                       output logic busy0, output logic done_next);
    a      = av;
    sh_amt = sv;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    a      = rnd64();
    sh_amt = rnd64();
    busy0  = busy;
    lat    = 0;
    while (!done && lat < TOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    got = d;
    @(posedge clk);
    #1;
    done_next = done;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    sh_amt = '0;
    #1;
    n_cmp++;
    if (d !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL reset_outputs: got d=%h done=%b busy=%b, want d=0 done=0 busy=0", d, done, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_op(input string name, input logic [DW-1:0] av, input logic [DW-1:0] sv);
    logic [DW-1:0] got;
    int            lat;
    logic          b0;
    logic          dn;
    logic [DW-1:0] exp_d;
    int            exp_lat;
    exp_d   = model_d(av, sv);
    exp_lat = model_lat(sv);
    do_op(av, sv, got, lat, b0, dn);
    n_cmp++;
    if (got !== exp_d) begin
      n_err++;
      $display("[TB] FAIL %s_d: a=%h sh=%h got d=%h want %h", name, av, sv, got, exp_d);
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_err++;
      $display("[TB] FAIL %s_latency: got %0d cycles want %0d", name, lat, exp_lat);
    end
    n_cmp++;
    if (b0 !== 1'b1 || dn !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL %s_handshake: got busy_after_accept=%b done_after_pulse=%b want 1/0", name, b0, dn);
    end
  endtask

  task automatic test_directed();
    check_op("zero_amt", 64'h1, 64'd0);
    check_op("amt20", 64'h1, 64'd20);
    check_op("amt64_ones", {DW{1'b1}}, 64'd64);
    check_op("msb_lsb_amt4", 64'h8000_0000_0000_0001, 64'd4);
    check_op("amt63", 64'h3, 64'd63);
    check_op("amt_huge", 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFC1);
  endtask

  task automatic test_random();
    logic [DW-1:0] av;
    logic [DW-1:0] sv;
    for (int i = 0; i < 24; i++) begin
      av = rnd64();
      if (i % 3 == 2) sv = rnd64();
      else            sv = DW'($urandom_range(0, 80));
      check_op("random", av, sv);
    end
  endtask

  // Request ignored while busy, then back-to-back start in the done cycle.
  task automatic test_back_to_back();
    int            lat;
    logic [DW-1:0] exp1;
    logic [DW-1:0] exp2;
    exp1 = model_d(64'h3, 64'd16);
    exp2 = model_d(64'h7, 64'd4);
    a      = 64'h3;
    sh_amt = 64'd16;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    a      = 64'h5;
    sh_amt = 64'd8;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 2;
    while (!done && lat < TOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== model_lat(64'd16) || d !== exp1) begin
      n_err++;
      $display("[TB] FAIL busy_interlock: got lat=%0d d=%h want lat=%0d d=%h", lat, d, model_lat(64'd16), exp1);
    end
    a      = 64'h7;
    sh_amt = 64'd4;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("[TB] FAIL back_to_back_accept: got done=%b busy=%b want done=0 busy=1", done, busy);
    end
    lat = 0;
    while (!done && lat < TOUT) begin
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== model_lat(64'd4) || d !== exp2) begin
      n_err++;
      $display("[TB] FAIL back_to_back_result: got lat=%0d d=%h want lat=%0d d=%h", lat, d, model_lat(64'd4), exp2);
    end
    @(posedge clk);
    #1;
  endtask

  // Reset in the middle of an operation, then a clean restart.
  task automatic test_reset_abort();
    int   saw_done;
    check_op("pre_abort", 64'h1, 64'd1);
    a      = 64'hFF;
    sh_amt = 64'd40;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (d !== '0 || done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL abort_async_clear: got d=%h done=%b busy=%b want 0/0/0", d, done, busy);
    end
    @(posedge clk);
    #2;
    rst    = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (done) saw_done++;
    end
    n_cmp++;
    if (saw_done !== 0) begin
      n_err++;
      $display("[TB] FAIL abort_no_done: got %0d done pulses want 0", saw_done);
    end
    check_op("after_abort", 64'h2, 64'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_shl_seq

// File: doc/shl_seq.md
SHL_SEQ -- requirements
Module: shl_seq

Interface
REQ-001 Parameter DATAWIDTH, default 64: operand, result and shift-amount width; SHALL be a power of two, at least 8.
REQ-002 Parameter STEP, default 8: maximum bit positions shifted per cycle; SHALL be a power of two, at most DATAWIDTH.
REQ-003 Clk  input  1  rising-edge clock for all state.
REQ-004 Rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  request; sampled only in IDLE.
REQ-006 a  input  DATAWIDTH  operand, captured on accepted start.
REQ-007 sh_amt  input  DATAWIDTH  shift amount, unsigned, captured on accepted start.
REQ-008 busy  output  1  high while an operation is in progress (state SHIFT).
REQ-009 done  output  1  one-cycle pulse marking d valid with the new result.
REQ-010 d  output  DATAWIDTH  registered result; holds its value until the next done.

Function
REQ-011 The FSM SHALL have two states: IDLE and SHIFT.
REQ-012 In IDLE, start=1 at a rising edge SHALL load acc=a and rem=amt_eff, then enter SHIFT.
REQ-013 Without rotate, amt_eff = min(sh_amt, DATAWIDTH); any sh_amt >= DATAWIDTH SHALL yield d=0.
REQ-014 rem SHALL be $clog2(DATAWIDTH)+1 bits wide.
REQ-015 In SHIFT with rem!=0, each edge SHALL set acc = acc << k and rem = rem - k, where k = min(rem, STEP); vacated bits fill with zero.
REQ-016 In SHIFT with rem==0, the edge SHALL set d=acc, drive done=1 for the following cycle, and return to IDLE.
REQ-017 Latency SHALL be N+1 cycles from the accepting edge to done high, where N = ceil(amt_eff/STEP); sh_amt=0 gives done one cycle after acceptance.
REQ-018 start while busy=1 SHALL be ignored, with no queuing and no effect on the result.
REQ-019 start may be asserted in the cycle done is high; it SHALL be accepted, giving back-to-back operation.
REQ-020 done SHALL be low in every cycle other than the one defined by REQ-016.
REQ-021 busy SHALL equal (state==SHIFT).
REQ-022 a and sh_amt SHALL be ignored except at the accepting edge.

Reset
REQ-023 Rst=1 SHALL asynchronously force state=IDLE, acc=0, rem=0, d=0, done=0 and busy=0, including mid-operation.
REQ-024 An aborted operation SHALL produce no done; the first rising edge after Rst deasserts SHALL accept start normally.

Configuration
REQ-025 Macro SHL_SEQ_ROTATE_EN defined: amt_eff = sh_amt mod DATAWIDTH (low $clog2(DATAWIDTH) bits), and each step SHALL rotate left, with bits leaving the MSB re-entering at the LSB.
REQ-026 Macro SHL_SEQ_ROTATE_EN undefined: logical shift with saturation per REQ-013; no rotate logic SHALL be present.

Structure
REQ-027 Shared package shl_seq_pkg SHALL hold the state encoding constants (IDLE, SHIFT) and the default STEP value.
REQ-028 A combinational sub-module shl_step SHALL compute one step from acc and k (shift, or rotate under the macro); shl_seq SHALL hold the FSM and all registers.

Verification (DATAWIDTH=64, STEP=8)
REQ-029 a=0x1, sh_amt=0 -> done one cycle after acceptance, d=0x1; busy high for one cycle.
REQ-030 a=0x1, sh_amt=20 -> three shift cycles, done four cycles after acceptance, d=0x100000.
REQ-031 a=all ones, sh_amt=64:
 - without macro: done at cycle 9, d=0;
 - with SHL_SEQ_ROTATE_EN: done at cycle 1, d=all ones.
REQ-032 a=0x8000000000000001, sh_amt=4:
 - without macro: d=0x10;
 - with macro: d=0x18.
REQ-033 Busy interlock: accept a=0x3, sh_amt=16, then pulse start with a=0x5 while busy -> single done, d=0x30000; start held high during the done cycle -> second operation accepted.
REQ-034 Rst pulse during SHIFT -> d=0, done=0, busy=0 immediately with no done for the aborted operation; next start (a=0x2, sh_amt=1) -> d=0x4 two cycles after acceptance.
